crot_pi_4_inv_gate_pipelined: RTL and testbench

Inverse controlled-phase rotation for theta = -pi/4, the conjugate gate used by the inverse-QFT datapath. When the control qubit is set, it multiplies complex amplitude (ar + j*ai) by e^{-j*pi/4}; when clear, it passes the amplitude through unchanged.
The block is a 3-stage pipeline with a valid/ready handshake at both ends and full back-pressure. It sits between amplitude-pair sources and the IQFT output buffer.

---
 rtl/crot_pi_4_inv_gate_pipelined_pkg.sv | 26 ++
 rtl/crot_pi_4_inv_gate_pipelined_fxp_sat_shift.sv | 39 +++
 rtl/crot_pi_4_inv_gate_pipelined.sv | 189 ++++++++++++++++++
 tb/tb_crot_pi_4_inv_gate_pipelined.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/crot_pi_4_inv_gate_pipelined_pkg.sv
// Shared fixed-point constants for the controlled-phase rotation gates.
// Both the forward and inverse pi/4 gates pull their widths, the
// 1/sqrt(2) coefficient and the saturation bounds from here, so the two
// datapaths always agree on number format.
//
// No ports (package).
package crot_pi_4_inv_gate_pipelined_pkg;

  // Signed amplitude format: S1.4 plus one bit of sign headroom.
  localparam int FXP_TOTAL_WIDTH = 6;
  localparam int FXP_FRAC_WIDTH  = 4;

  // Sum/difference of two amplitudes needs one extra bit.
  localparam int FXP_ADD_WIDTH = FXP_TOTAL_WIDTH + 1;

  // Product of a sum/difference with a FRAC_WIDTH-bit coefficient.
  localparam int FXP_MULT_RESULT_WIDTH = FXP_ADD_WIDTH + FXP_FRAC_WIDTH;

  // 1/sqrt(2) ~= 11/16 = 0.6875 in the FRAC_WIDTH fractional format.
  localparam int FXP_C_VAL = 11;

  // Clamp bounds of a TOTAL_WIDTH signed result.
  localparam int FXP_SAT_MAX = (1 << (FXP_TOTAL_WIDTH - 1)) - 1;
  localparam int FXP_SAT_MIN = -(1 << (FXP_TOTAL_WIDTH - 1));

endpackage

// File: rtl/crot_pi_4_inv_gate_pipelined_fxp_sat_shift.sv
// Fixed-point rescale: arithmetic right shift by SHIFT bits (truncation
// toward minus infinity) followed by a clamp into an OUT_W signed range.
// Used twice in the last stage of the rotation gates.
//
// Ports:
//   x  in  IN_W   signed product to be rescaled
//   y  out OUT_W  signed, shifted and saturated result
module crot_pi_4_inv_gate_pipelined_fxp_sat_shift
  import crot_pi_4_inv_gate_pipelined_pkg::*;
#(
  parameter int IN_W    = FXP_MULT_RESULT_WIDTH,
  parameter int SHIFT   = FXP_FRAC_WIDTH,
  parameter int OUT_W   = FXP_TOTAL_WIDTH,
  parameter int SAT_MAX = FXP_SAT_MAX,
  parameter int SAT_MIN = FXP_SAT_MIN
) (
  input  logic signed [IN_W-1:0]  x,
  output logic signed [OUT_W-1:0] y
);

  // Bounds sign-extended to the input width so the compares are signed
  // and the clamp can never wrap.
  localparam logic signed [IN_W-1:0] MAX_V = IN_W'(SAT_MAX);
  localparam logic signed [IN_W-1:0] MIN_V = IN_W'(SAT_MIN);

  logic signed [IN_W-1:0] shifted;

  always_comb begin
    shifted = x >>> SHIFT;
    if (shifted > MAX_V) begin
      y = MAX_V[OUT_W-1:0];
    end else if (shifted < MIN_V) begin
      y = MIN_V[OUT_W-1:0];
    end else begin
      y = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/crot_pi_4_inv_gate_pipelined.sv
// Inverse controlled-phase rotation, theta = -pi/4, 3-stage pipeline.
// With in_ctrl=1 the amplitude (ar + j*ai) is multiplied by e^{-j*pi/4}:
//   pr = (ar + ai) / sqrt(2),  pi = (ai - ar) / sqrt(2)
// With in_ctrl=0 the amplitude passes through bit-exact.
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input amplitude valid
//   in_ready   out  block can accept an input this cycle
//   in_ctrl    in   control qubit: 1 = rotate, 0 = pass-through
//   ar, ai     in   input real / imaginary part, signed TOTAL_WIDTH
//   out_valid  out  output amplitude valid
//   out_ready  in   downstream accepts output
//   pr, pi     out  output real / imaginary part, signed TOTAL_WIDTH
//
// Handshake: an item moves across an interface on a rising clk edge where
// valid & ready are both 1. A producer holding valid keeps its data stable
// until it is taken; in_ready never looks at in_valid, and out_valid/pr/pi
// hold steady while out_ready is 0. Each stage advances when it is empty
// or the stage after it advances, so in_ready is a combinational function
// of out_ready and the stage valid bits and the pipe never inserts bubbles.
module crot_pi_4_inv_gate_pipelined
  import crot_pi_4_inv_gate_pipelined_pkg::*;
#(
  parameter int TOTAL_WIDTH = FXP_TOTAL_WIDTH,
  parameter int FRAC_WIDTH  = FXP_FRAC_WIDTH,
  // Coefficient must fit in FRAC_WIDTH bits; it is realised as a sum of
  // shifted copies of the operand (for 11: (x<<3)+(x<<1)+x).
  parameter int C_VAL       = FXP_C_VAL
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_ctrl,
  input  logic signed [TOTAL_WIDTH-1:0] ar,
  input  logic signed [TOTAL_WIDTH-1:0] ai,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [TOTAL_WIDTH-1:0] pr,
  output logic signed [TOTAL_WIDTH-1:0] pi
);

  localparam int ADD_W  = TOTAL_WIDTH + 1;
  localparam int MULT_W = ADD_W + FRAC_WIDTH;

  // Stage valid bits and advance enables.
  logic v1, v2, v3;
  logic adv1, adv2, adv3;

  // Stage 1: sum/difference plus the raw amplitude for the bypass path.
  logic                          c1;
  logic signed [ADD_W-1:0]       s1, d1;
  logic signed [TOTAL_WIDTH-1:0] ar1, ai1;

  // Stage 2: products with the coefficient, bypass amplitude carried along.
  logic                          c2;
  logic signed [MULT_W-1:0]      ps2, pd2;
  logic signed [TOTAL_WIDTH-1:0] ar2, ai2;

  // Stage 3: output registers.
  logic signed [TOTAL_WIDTH-1:0] pr3, pi3;

  // Combinational next values between stages.
  logic signed [ADD_W-1:0]       s_c, d_c;
  logic signed [MULT_W-1:0]      s_ext, d_ext;
  logic signed [MULT_W-1:0]      ps_c, pd_c;
  logic signed [TOTAL_WIDTH-1:0] rot_r, rot_i;
  logic signed [TOTAL_WIDTH-1:0] pr_c, pi_c;

  // ---------------------------------------------------------------------
  // Pipeline control
  // ---------------------------------------------------------------------
  assign adv3     = !v3 || out_ready;
  assign adv2     = !v2 || adv3;
  assign adv1     = !v1 || adv2;
  assign in_ready = adv1;

  assign out_valid = v3;
  assign pr        = pr3;
  assign pi        = pi3;

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  assign s_c = ADD_W'(ar) + ADD_W'(ai);
  assign d_c = ADD_W'(ai) - ADD_W'(ar);

  assign s_ext = MULT_W'(s1);
  assign d_ext = MULT_W'(d1);

  // Constant coefficient as shift-and-add; no multiplier is built.
  always_comb begin
    ps_c = '0;
    pd_c = '0;
    for (int b = 0; b < 31; b++) begin
      if (C_VAL[b]) begin
        ps_c = ps_c + (s_ext <<< b);
        pd_c = pd_c + (d_ext <<< b);
      end
    end
  end

  crot_pi_4_inv_gate_pipelined_fxp_sat_shift #(
    .IN_W   (MULT_W),
    .SHIFT  (FRAC_WIDTH),
    .OUT_W  (TOTAL_WIDTH),
    .SAT_MAX((1 << (TOTAL_WIDTH - 1)) - 1),
    .SAT_MIN(-(1 << (TOTAL_WIDTH - 1)))
  ) u_sat_r (
    .x(ps2),
    .y(rot_r)
  );

  crot_pi_4_inv_gate_pipelined_fxp_sat_shift #(
    .IN_W   (MULT_W),
    .SHIFT  (FRAC_WIDTH),
    .OUT_W  (TOTAL_WIDTH),
    .SAT_MAX((1 << (TOTAL_WIDTH - 1)) - 1),
    .SAT_MIN(-(1 << (TOTAL_WIDTH - 1)))
  ) u_sat_i (
    .x(pd2),
    .y(rot_i)
  );

  // Pass-through keeps the original amplitude bits untouched.
  assign pr_c = c2 ? rot_r : ar2;
  assign pi_c = c2 ? rot_i : ai2;

  // ---------------------------------------------------------------------
  // Stage registers. Data only loads when a valid item enters a stage,
  // so a stage that drains keeps its last contents harmlessly.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      c1  <= 1'b0;
      s1  <= '0;
      d1  <= '0;
      ar1 <= '0;
      ai1 <= '0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        c1  <= in_ctrl;
        s1  <= s_c;
        d1  <= d_c;
        ar1 <= ar;
        ai1 <= ai;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2  <= 1'b0;
      c2  <= 1'b0;
      ps2 <= '0;
      pd2 <= '0;
      ar2 <= '0;
      ai2 <= '0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        c2  <= c1;
        ps2 <= ps_c;
        pd2 <= pd_c;
        ar2 <= ar1;
        ai2 <= ai1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3  <= 1'b0;
      pr3 <= '0;
      pi3 <= '0;
    end else if (adv3) begin
      v3 <= v2;
      if (v2) begin
        pr3 <= pr_c;
        pi3 <= pi_c;
      end
    end
  end

endmodule

// File: tb/tb_crot_pi_4_inv_gate_pipelined.sv
// Directed bench for the inverse pi/4 controlled rotation pipeline.
module tb_crot_pi_4_inv_gate_pipelined;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_ctrl = 1'b0;
  logic signed [5:0] ar = '0;
  logic signed [5:0] ai = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic signed [5:0] pr;
  logic signed [5:0] pi;

  crot_pi_4_inv_gate_pipelined dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .ar       (ar),
    .ai       (ai),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .pr       (pr),
    .pi       (pi)
  );

  int errors = 0;
  int checks = 0;

  // Pending stimulus and scoreboard ({pr, pi} per item).
  logic signed [5:0] q_ar[$];
  logic signed [5:0] q_ai[$];
  logic              q_ctrl[$];
  logic [11:0]       exp_q[$];

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp_v));
    end
  endtask

  // Reference: floor(11*x/16) clamped to [-32, 31].
  function automatic logic [5:0] rot_part(input int x);
    int v;
    int q;
    v = 11 * x;
    if (v >= 0) q = v / 16;
    else q = -((-v + 15) / 16);
    if (q > 31) q = 31;
    if (q < -32) q = -32;
    return q[5:0];
  endfunction

  function automatic logic [11:0] model(input int a, input int b, input logic c);
    if (c) return {rot_part(a + b), rot_part(b - a)};
    return {a[5:0], b[5:0]};
  endfunction

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic push(input int a, input int b, input logic c, input int epr, input int epi);
    q_ar.push_back(a[5:0]);
    q_ai.push_back(b[5:0]);
    q_ctrl.push_back(c);
    exp_q.push_back({epr[5:0], epi[5:0]});
  endtask

  // Feeds every queued item back-to-back, drops out_ready for stall_len
  // cycles from cycle stall_start, and scores each output. Cycle numbers
  // count negedges from the start of the call; an item presented at
  // cycle 0 with no stall is expected at cycle 3.
  task automatic run_stream(input string tag, input int stall_start, input int stall_len,
                            output int first_pop, output int last_pop);
    int          acc;
    int          pops;
    logic        was_stalled;
    logic [5:0]  hold_pr;
    logic [5:0]  hold_pi;
    logic [11:0] e;
    acc = 0;
    pops = 0;
    first_pop = -1;
    last_pop = -1;
    was_stalled = 1'b0;
    hold_pr = '0;
    hold_pi = '0;
    for (int c = 0; c < 80; c++) begin
      if (q_ar.size() == 0 && exp_q.size() == 0) break;
      @(negedge clk);
      out_ready = !(c >= stall_start && c < stall_start + stall_len);
      if (q_ar.size() > 0) begin
        in_valid = 1'b1;
        ar = q_ar[0];
        ai = q_ai[0];
        in_ctrl = q_ctrl[0];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (was_stalled) begin
        check({tag, "_stall_valid"}, 6'(out_valid), 6'd1);
        check({tag, "_stall_pr"}, pr, hold_pr);
        check({tag, "_stall_pi"}, pi, hold_pi);
      end
      if (!out_ready && (acc - pops) >= 3) check({tag, "_full_in_ready"}, 6'(in_ready), 6'd0);
      if (out_ready) check({tag, "_in_ready"}, 6'(in_ready), 6'd1);
      if (in_valid && in_ready) begin
        void'(q_ar.pop_front());
        void'(q_ai.pop_front());
        void'(q_ctrl.pop_front());
        acc++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL %s_extra: observed unexpected output pr=%0d pi=%0d", tag, pr, pi);
        end else begin
          e = exp_q.pop_front();
          check({tag, "_pr"}, pr, e[11:6]);
          check({tag, "_pi"}, pi, e[5:0]);
        end
        if (first_pop < 0) first_pop = c;
        last_pop = c;
        pops++;
      end
      was_stalled = out_valid && !out_ready;
      hold_pr = pr;
      hold_pi = pi;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (q_ar.size() != 0 || exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout: observed %0d items pending, expected 0", tag, exp_q.size());
      q_ar.delete();
      q_ai.delete();
      q_ctrl.delete();
      exp_q.delete();
    end
  endtask

  // ---------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------
  initial begin
    int          fp;
    int          lp;
    logic [5:0]  ra;
    logic [5:0]  rb;
    logic        rc;
    logic [11:0] e;

    // Reset state.
    rst_n = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", 6'(out_valid), 6'd0);
    check("rst_pr", pr, 6'd0);
    check("rst_pi", pi, 6'd0);
    check("rst_in_ready", 6'(in_ready), 6'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic rotation and latency.
    push(16, 0, 1'b1, 11, -11);
    run_stream("t1", 1000, 0, fp, lp);
    check("t1_latency", fp[5:0], 6'd3);

    // More rotations back-to-back, including truncation toward -inf.
    push(0, 16, 1'b1, 11, 11);
    push(-16, -16, 1'b1, -22, 0);
    push(1, 0, 1'b1, 0, -1);
    run_stream("t2", 1000, 0, fp, lp);
    check("t2_first", fp[5:0], 6'd3);
    check("t2_last", lp[5:0], 6'd5);

    // Saturation at both ends.
    push(31, 31, 1'b1, 31, 0);
    push(-32, 31, 1'b1, -1, 31);
    push(-32, -32, 1'b1, -32, 0);
    run_stream("t3", 1000, 0, fp, lp);

    // Bypass and interleaved modes.
    push(-7, 13, 1'b0, -7, 13);
    push(5, -3, 1'b0, 5, -3);
    push(5, -3, 1'b1, 1, -6);
    push(-20, 10, 1'b0, -20, 10);
    push(-20, 10, 1'b1, -7, 20);
    run_stream("t4", 1000, 0, fp, lp);
    check("t4_latency", fp[5:0], 6'd3);

    // Ten items with random control, 5-cycle stall mid-stream.
    for (int i = 0; i < 10; i++) begin
      ra = 6'($urandom_range(0, 63));
      rb = 6'($urandom_range(0, 63));
      rc = 1'($urandom_range(0, 1));
      e = model(int'($signed(ra)), int'($signed(rb)), rc);
      q_ar.push_back(ra);
      q_ai.push_back(rb);
      q_ctrl.push_back(rc);
      exp_q.push_back(e);
    end
    run_stream("t5", 4, 5, fp, lp);
    check("t5_first", fp[5:0], 6'd3);
    check("t5_last", lp[5:0], 6'd17);

    // Reset with three items in flight.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_ctrl = 1'b1;
      ar = 6'sd5;
      ai = 6'sd5;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("t6_loaded_valid", 6'(out_valid), 6'd1);
    check("t6_loaded_pr", pr, 6'd6);
    check("t6_full_in_ready", 6'(in_ready), 6'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_out_valid", 6'(out_valid), 6'd0);
    check("t6_rst_pr", pr, 6'd0);
    check("t6_rst_pi", pi, 6'd0);
    check("t6_rst_in_ready", 6'(in_ready), 6'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    push(0, 16, 1'b1, 11, 11);
    run_stream("t6", 1000, 0, fp, lp);
    check("t6_latency", fp[5:0], 6'd3);

    // Report.
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
